dispatch_window: RTL
====================

# dispatch_window

Registered window of up to FETCH_WIDTH renamed ops sitting between the rename stage and the per-type sorter. Each cycle it retires the slots the sorter reports as used, compacts the survivors toward slot 0 in program order, and refills free slots from the rename group. The rename group is accepted partially through a lane-used mask, which keeps the window full whenever upstream has ops available.

## Interface
Parameters:
- FETCH_WIDTH, 4: slot count; also the width of the rename group.
- OP_W, 47: renamed-op width; must equal the package constant RENAMED_OP_SZ.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard the window and accept nothing this cycle.
- in_ops  in  FETCH_WIDTH*OP_W  rename group; lane i is at [i*OP_W +: OP_W].
- in_valid  in  FETCH_WIDTH  lane valid mask, contiguous from lane 0.
- in_used  out  FETCH_WIDTH  lanes accepted this cycle; upstream drops these lanes.
- win_ops  out  FETCH_WIDTH*OP_W  registered window contents; slot 0 is the oldest op.
- win_valid  out  FETCH_WIDTH  registered, contiguous from slot 0.
- win_used  in  FETCH_WIDTH  slots consumed this cycle, driven by the sorter.
- occupancy  out  $clog2(FETCH_WIDTH+1)  registered popcount of win_valid.

## Operation
- Effective removal mask: rm = win_used & win_valid. Bits of win_used on invalid slots are ignored.
- The rm mask may be non-contiguous, e.g. 4'b0101. Survivors keep relative order and pack into slots 0..s-1, where s = occupancy - popcount(rm).
- Free space: f = FETCH_WIDTH - s.
- in_used is the lowest min(f, popcount(in_valid)) bits of in_valid.
- Accepted lanes fill slots s, s+1, … in lane order.
- Next state:
  - win_valid' = low (s + accepted) bits set.
  - occupancy' = s + accepted.
  - Unfilled slots keep win_valid = 0; their win_ops value is don't-care.
- flush = 1:
  - next state is all slots invalid, occupancy' = 0.
  - in_used = 0 regardless of win_used and in_valid.
  - flush overrides same-cycle removal and refill.
- rst = 1:
  - win_valid, occupancy and in_used are 0 (in_used is forced to 0 combinationally while rst is high).
  - win_ops is reset to 0.
- Non-contiguous in_valid is illegal upstream behaviour. The bench asserts on it, and the RTL treats only the leading contiguous run as valid.
- The window never overflows: accepted ≤ f by construction.

## Timing
- in_used is combinational from win_used, in_valid, flush, rst and registered state. There is no path from in_used back to win_used.
- win_used is combinational in the sorter from win_ops/win_valid (registered here) and the downstream ready signals, so no loop exists.
- An op accepted in cycle t appears in win_ops at cycle t+1. It can be used at t+1 at the earliest, and its slot is freed at t+2.
- A full window (occupancy = FETCH_WIDTH) with rm = 0 gives in_used = 0. Slots freed in cycle t are refilled in the same cycle t, visible at t+1. There is zero-bubble back-to-back throughput.
- An empty window with in_valid = 0 holds its state.
- rst or flush asserted mid-stream takes effect at the next edge. Ops presented on in_ops that cycle are not consumed, because in_used = 0.

## Structure
- Shared package holds:
  - RENAMED_OP_SZ = 47;
  - the opcode field position [46:43] and the dest field [42:33], for bench decoding;
  - a count-width helper.
- One sub-module, slot_compact #(N, W):
  - input: data, valid and remove mask;
  - output: order-preserving packed data and the survivor count;
  - implementation: prefix popcount of the survivors selects each destination slot (a mux per output slot).
- The top level contains the compaction instance, the lane-select logic (prefix popcount of in_valid against f), the slot-fill muxing and the registers.

## Test plan
- Reset then fill: rst for 2 cycles, then in_valid = 4'b1111 with ops A,B,C,D.
  - During rst, in_used = 0.
  - First cycle after: in_used = 4'b1111. Next cycle win_valid = 4'b1111, slots A,B,C,D, occupancy = 4.
- Holed removal with refill:
  - Window A,B,C,D; win_used = 4'b0101; in_valid = 4'b0111 with E,F,G.
  - in_used = 4'b0011. Next window B,D,E,F, occupancy = 4.
- Full stall: window full, win_used = 0, in_valid = 4'b1111 -> in_used = 0 and the window is unchanged for 5 cycles.
- Ignored bits on invalid slots:
  - Window A,B (win_valid = 4'b0011); win_used = 4'b1110; in_valid = 0.
  - Next window A only, occupancy = 1.
- Flush precedence: window full, win_used = 4'b1111, in_valid = 4'b1111, flush = 1 -> in_used = 0; next win_valid = 0, occupancy = 0.
- Random soak (10k cycles): random win_used and contiguous in_valid.
  - Scoreboard checks that ops leave in exact program order with no loss or duplication.
  - Checks occupancy equals popcount(win_valid) every cycle.

Source files
------------

// File: rtl/dispatch_window_pkg.sv
// Shared definitions for the dispatch window: renamed-op layout and sizing helpers.
package dispatch_window_pkg;

  localparam int unsigned RENAMED_OP_SZ = 47;

  // Field positions inside a renamed op, used when decoding window contents.
  localparam int unsigned OPC_MSB  = 46;
  localparam int unsigned OPC_LSB  = 43;
  localparam int unsigned DEST_MSB = 42;
  localparam int unsigned DEST_LSB = 33;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [9:0]  dest;
    logic [32:0] payload;
  } renamed_op_t;

  // Width needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/slot_compact.sv
// Order-preserving compaction: survivors (valid & ~remove) pack toward slot 0.
module slot_compact
  import dispatch_window_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = RENAMED_OP_SZ
) (
  input  logic [N*W-1:0]        data,
  input  logic [N-1:0]          valid,
  input  logic [N-1:0]          remove,
  output logic [N*W-1:0]        packed_data,
  output logic [cnt_w(N)-1:0]   count
);

  localparam int unsigned CW = cnt_w(N);

  logic [N-1:0]  keep;
  logic [CW-1:0] rank [N];
  logic [CW-1:0] acc;

  assign keep = valid & ~remove;

  // Prefix popcount of survivors gives each one its destination slot.
  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      rank[i] = acc;
      acc     = acc + CW'(keep[i]);
    end
    count = acc;
  end

  always_comb begin
    packed_data = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (keep[i] && (rank[i] == CW'(j))) begin
          packed_data[j*W +: W] = data[i*W +: W];
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_window.sv
// Registered window of renamed ops: retires used slots, compacts survivors,
// and refills free slots from the rename group in program order.
module dispatch_window
  import dispatch_window_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned OP_W        = RENAMED_OP_SZ
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [FETCH_WIDTH*OP_W-1:0]         in_ops,
  input  logic [FETCH_WIDTH-1:0]              in_valid,
  output logic [FETCH_WIDTH-1:0]              in_used,
  output logic [FETCH_WIDTH*OP_W-1:0]         win_ops,
  output logic [FETCH_WIDTH-1:0]              win_valid,
  input  logic [FETCH_WIDTH-1:0]              win_used,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]    occupancy
);

  localparam int unsigned N  = FETCH_WIDTH;
  localparam int unsigned CW = cnt_w(FETCH_WIDTH);

  logic [N-1:0]      rm;
  logic [N*OP_W-1:0] packed_ops;
  logic [CW-1:0]     surv;
  logic [CW-1:0]     free;
  logic [CW-1:0]     acc_cnt;
  logic              live;
  logic [CW-1:0]     total;
  logic [N*OP_W-1:0] nxt_ops;
  logic [N-1:0]      nxt_valid;

  assign rm   = win_used & win_valid;
  assign free = CW'(N) - surv;

  slot_compact #(.N(N), .W(OP_W)) u_compact (
    .data        (win_ops),
    .valid       (win_valid),
    .remove      (rm),
    .packed_data (packed_ops),
    .count       (surv)
  );

  // Accept lanes from the leading contiguous run of in_valid while space remains.
  always_comb begin
    in_used = '0;
    acc_cnt = '0;
    live    = 1'b1;
    for (int i = 0; i < N; i++) begin
      live = live & in_valid[i];
      if (live && (acc_cnt < free) && !flush && !rst) begin
        in_used[i] = 1'b1;
        acc_cnt    = acc_cnt + CW'(1);
      end
    end
  end

  // Accepted lane k lands in slot surv + k.
  always_comb begin
    nxt_ops   = packed_ops;
    nxt_valid = '0;
    total     = surv + acc_cnt;
    for (int j = 0; j < N; j++) begin
      nxt_valid[j] = (CW'(j) < total);
      for (int k = 0; k < N; k++) begin
        if (in_used[k] && ((int'(surv) + k) == j)) begin
          nxt_ops[j*OP_W +: OP_W] = in_ops[k*OP_W +: OP_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_ops   <= '0;
      win_valid <= '0;
      occupancy <= '0;
    end else if (flush) begin
      win_valid <= '0;
      occupancy <= '0;
    end else begin
      win_ops   <= nxt_ops;
      win_valid <= nxt_valid;
      occupancy <= total;
    end
  end

endmodule
